// File: rtl/iterative_mul_unit.sv
// iterative_mul_unit: shift-add RV32M multiplier, one multiplier bit per cycle, 33-cycle fixed latency
module iterative_mul_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      funct3E,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            flagM,
  output logic [XLEN-1:0] result_m
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op;
  logic neg, a_neg, b_neg, accept, last;
  logic [2*XLEN-1:0] mcand, acc, acc_n, prod;
  logic [XLEN-1:0] mplier, mag_a, mag_b;
  logic [CNT_W-1:0] count;
  // operand magnitudes, final-iteration accumulator and the signed product it produces
  always_comb begin
    a_neg  = SrcA[XLEN-1] & (funct3E == 2'b01 | funct3E == 2'b10);
    b_neg  = SrcB[XLEN-1] & (funct3E == 2'b01);
    mag_a  = a_neg ? -SrcA : SrcA;
    mag_b  = b_neg ? -SrcB : SrcB;
    accept = state == IDLE & start & ~flush;
    last   = count == CNT_W'(XLEN - 1);
    acc_n  = acc + (mplier[0] ? mcand : '0);
    prod   = neg ? ~acc_n + 1'b1 : acc_n;
  end
  // next state and handshake outputs; DONE never re-accepts because the same instruction is still in EX
  always_comb begin
    state_n = accept ? RUN : state == RUN ? (flush ? IDLE : last ? DONE : RUN) : IDLE;
    busy    = state == RUN | accept;
    flagM   = state == DONE & ~flush;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // datapath: latch on acceptance, iterate in RUN, capture the result on the last iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      neg      <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result_m <= '0;
    end else if (accept) begin
      op     <= funct3E;
      neg    <= a_neg ^ b_neg;
      mcand  <= {{XLEN{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN && !flush) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last) result_m <= op == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end
endmodule
